// File: rtl/test_access_ctrl.sv
// ----------------------------------------------------------------------------
// test_access_ctrl
// Host-side sequencer for the SystemTest debug port of the 16-bit multicycle
// CPU. It accepts one host command at a time and carries it out on the
// debug port with the required multi-cycle timing:
//   MEMRD/MEMWR/REGRD/REGWR : the access strobe is held ACC_CYCLES cycles,
//                             then one check cycle samples MD/RD.
//   RUN                     : one cycle of cpu_reset with resetpc, then
//                             test=1 until N instructions have completed.
// The controller is the only master of the debug port. The CPU runs only
// while this block drives test high.
//
// Optional feature (compile-time macro TAC_WATCHDOG_EN): a RUN that has not
// completed after WDOG_CYCLES cycles is aborted with rsp_err=1.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmd_valid/ready     host command handshake (accepted when both high)
//   cmd_op/addr/data    0 MEMRD, 1 MEMWR, 2 REGRD, 3 REGWR, 4 RUN; 5-7 illegal
//   rsp_valid           one-cycle response pulse
//   rsp_data/rsp_err    response fields, held until the next response
//   test, cpu_reset,    CPU run enable, reset and reset vector
//   resetpc
//   memoryoperation,    memory debug access (select, write strobe, address,
//   memorywrite, ...    write data)
//   registeroperation,  register-file debug access (select, write strobe,
//   registerwrite, ...  index, write data)
//   MD, RD, PC,         read data, program counter and control state from
//   cpu_state           the CPU
// ----------------------------------------------------------------------------
module test_access_ctrl #(
   parameter int         ACC_CYCLES  = 2,
   parameter logic [8:0] FETCH_STATE = 9'd1,
   parameter int         WDOG_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        test,
   output logic        cpu_reset,
   output logic [15:0] resetpc,
   output logic        memoryoperation,
   output logic        memorywrite,
   output logic [15:0] memaddress,
   output logic [15:0] memwritedata,
   output logic        registeroperation,
   output logic        registerwrite,
   output logic [3:0]  registeraddress,
   output logic [15:0] regwritedata,
   input  logic [15:0] MD,
   input  logic [15:0] RD,
   input  logic [15:0] PC,
   input  logic [8:0]  cpu_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACC   = 3'd1,
      S_CHECK = 3'd2,
      S_RST   = 3'd3,
      S_RUN   = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   localparam logic [2:0] OP_MEMRD = 3'd0;
   localparam logic [2:0] OP_MEMWR = 3'd1;
   localparam logic [2:0] OP_REGRD = 3'd2;
   localparam logic [2:0] OP_REGWR = 3'd3;
   localparam logic [2:0] OP_RUN   = 3'd4;

   // Access counter only needs to reach ACC_CYCLES-1.
   localparam int            ACW      = (ACC_CYCLES < 2) ? 1 : $clog2(ACC_CYCLES);
   localparam logic [ACW-1:0] ACC_LAST = ACW'(ACC_CYCLES - 1);

`ifdef TAC_WATCHDOG_EN
   localparam int            WDW       = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES);
`endif

   function automatic logic is_mem_op(input logic [2:0] op);
      return (op == OP_MEMRD) || (op == OP_MEMWR);
   endfunction

   function automatic logic is_write_op(input logic [2:0] op);
      return (op == OP_MEMWR) || (op == OP_REGWR);
   endfunction

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [15:0]    addr_q, addr_d;
   logic [15:0]    data_q, data_d;
   logic [ACW-1:0] acc_cnt_q, acc_cnt_d;
   logic [15:0]    remain_q, remain_d;
   logic           fetch_prev_q, fetch_prev_d;
   logic [15:0]    rsp_data_q, rsp_data_d;
   logic           rsp_err_q, rsp_err_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           cmd_ready_q, cmd_ready_d;
   logic           test_q, test_d;
   logic           cpu_reset_q, cpu_reset_d;
   logic [15:0]    resetpc_q, resetpc_d;
   logic           mem_sel_q, mem_sel_d;
   logic           mem_wr_q, mem_wr_d;
   logic [15:0]    mem_addr_q, mem_addr_d;
   logic [15:0]    mem_wdata_q, mem_wdata_d;
   logic           reg_sel_q, reg_sel_d;
   logic           reg_wr_q, reg_wr_d;
   logic [3:0]     reg_addr_q, reg_addr_d;
   logic [15:0]    reg_wdata_q, reg_wdata_d;
`ifdef TAC_WATCHDOG_EN
   logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

   logic [15:0]    sampled_s;
   logic           fetch_entry_s;
   logic           run_stop_s;

   // Next-state, command latch, response and registered-output decode.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      data_d        = data_q;
      acc_cnt_d     = acc_cnt_q;
      remain_d      = remain_q;
      fetch_prev_d  = fetch_prev_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      run_stop_s    = 1'b0;
      sampled_s     = is_mem_op(op_q) ? MD : RD;
      // A fetch entry is the first cycle cpu_state shows FETCH_STATE.
      fetch_entry_s = (cpu_state == FETCH_STATE) && !fetch_prev_q;
`ifdef TAC_WATCHDOG_EN
      wdog_cnt_d    = wdog_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d         = cmd_op;
               addr_d       = cmd_addr;
               data_d       = cmd_data;
               acc_cnt_d    = {ACW{1'b0}};
               remain_d     = cmd_data;
               // Cleared so the first fetch after the CPU reset counts.
               fetch_prev_d = 1'b0;
`ifdef TAC_WATCHDOG_EN
               wdog_cnt_d   = {WDW{1'b0}};
`endif
               case (cmd_op)
                  OP_MEMRD, OP_MEMWR, OP_REGRD, OP_REGWR: state_d = S_ACC;
                  OP_RUN: state_d = S_RST;
                  default: begin
                     state_d    = S_RESP;
                     rsp_data_d = 16'h0000;
                     rsp_err_d  = 1'b1;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ACC: begin
            if (acc_cnt_q == ACC_LAST) begin
               state_d = S_CHECK;
            end else begin
               acc_cnt_d = acc_cnt_q + ACW'(1);
            end
         end

         S_CHECK: begin
            rsp_data_d = sampled_s;
            rsp_err_d  = is_write_op(op_q) ? (sampled_s != data_q) : 1'b0;
            state_d    = S_RESP;
         end

         S_RST: begin
            state_d = S_RUN;
         end

         S_RUN: begin
            fetch_prev_d = (cpu_state == FETCH_STATE);
            // remain counts down entries still to see; the entry that finds
            // it at zero is the (N+1)th, so 16'hFFFF never wraps.
            if (fetch_entry_s && (remain_q == 16'h0000)) begin
               run_stop_s = 1'b1;
               rsp_data_d = PC;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else begin
               if (fetch_entry_s) begin
                  remain_d = remain_q - 16'h0001;
               end else begin
                  remain_d = remain_q;
               end
`ifdef TAC_WATCHDOG_EN
               if (wdog_cnt_q == WDOG_LAST) begin
                  run_stop_s = 1'b1;
                  rsp_data_d = PC;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  wdog_cnt_d = wdog_cnt_q + WDW'(1);
               end
`endif
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Port values are decoded from the next state so they come from flops.
      cmd_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
      test_d      = (state_d == S_RUN);
      cpu_reset_d = (state_d == S_RST);
      resetpc_d   = cpu_reset_d ? addr_d : 16'h0000;
      mem_sel_d   = is_mem_op(op_d) && ((state_d == S_ACC) || (state_d == S_CHECK));
      reg_sel_d   = !is_mem_op(op_d) && (op_d != OP_RUN) &&
                    ((state_d == S_ACC) || (state_d == S_CHECK));
      mem_wr_d    = mem_sel_d && is_write_op(op_d) && (state_d == S_ACC);
      reg_wr_d    = reg_sel_d && is_write_op(op_d) && (state_d == S_ACC);
      mem_addr_d  = mem_sel_d ? addr_d : 16'h0000;
      mem_wdata_d = (mem_sel_d && is_write_op(op_d)) ? data_d : 16'h0000;
      reg_addr_d  = reg_sel_d ? addr_d[3:0] : 4'h0;
      reg_wdata_d = (reg_sel_d && is_write_op(op_d)) ? data_d : 16'h0000;
   end

   // State, command and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= 3'd0;
         addr_q       <= 16'h0000;
         data_q       <= 16'h0000;
         acc_cnt_q    <= {ACW{1'b0}};
         remain_q     <= 16'h0000;
         fetch_prev_q <= 1'b0;
         rsp_data_q   <= 16'h0000;
         rsp_err_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         cmd_ready_q  <= 1'b1;
         test_q       <= 1'b0;
         cpu_reset_q  <= 1'b0;
         resetpc_q    <= 16'h0000;
         mem_sel_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= 16'h0000;
         mem_wdata_q  <= 16'h0000;
         reg_sel_q    <= 1'b0;
         reg_wr_q     <= 1'b0;
         reg_addr_q   <= 4'h0;
         reg_wdata_q  <= 16'h0000;
`ifdef TAC_WATCHDOG_EN
         wdog_cnt_q   <= {WDW{1'b0}};
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         acc_cnt_q    <= acc_cnt_d;
         remain_q     <= remain_d;
         fetch_prev_q <= fetch_prev_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
         cmd_ready_q  <= cmd_ready_d;
         test_q       <= test_d;
         cpu_reset_q  <= cpu_reset_d;
         resetpc_q    <= resetpc_d;
         mem_sel_q    <= mem_sel_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         reg_sel_q    <= reg_sel_d;
         reg_wr_q     <= reg_wr_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
`ifdef TAC_WATCHDOG_EN
         wdog_cnt_q   <= wdog_cnt_d;
`endif
      end
   end

   assign cmd_ready         = cmd_ready_q;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_data          = rsp_data_q;
   assign rsp_err           = rsp_err_q;
   // test must fall in the very cycle the stop is seen so the CPU halts in
   // fetch; this is the one output with a combinational term.
   assign test              = test_q && !run_stop_s;
   assign cpu_reset         = cpu_reset_q;
   assign resetpc           = resetpc_q;
   assign memoryoperation   = mem_sel_q;
   assign memorywrite       = mem_wr_q;
   assign memaddress        = mem_addr_q;
   assign memwritedata      = mem_wdata_q;
   assign registeroperation = reg_sel_q;
   assign registerwrite     = reg_wr_q;
   assign registeraddress   = reg_addr_q;
   assign regwritedata      = reg_wdata_q;

endmodule

// File: tb/tb_test_access_ctrl.sv
// Bench for test_access_ctrl: a small memory, register file and stepping CPU
// surround the controller. A command-level reference model predicts every
// response.
module tb_test_access_ctrl;

   localparam int         ACC   = 2;
   localparam logic [7:0] FAULT = 8'hF0;   // this memory cell reads back with bit0 flipped

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_addr, cmd_data;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_data;
   logic        test, cpu_reset;
   logic [15:0] resetpc;
   logic        memoryoperation, memorywrite;
   logic [15:0] memaddress, memwritedata;
   logic        registeroperation, registerwrite;
   logic [3:0]  registeraddress;
   logic [15:0] regwritedata;
   logic [15:0] MD, RD, PC;
   logic [8:0]  cpu_state;

   test_access_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .test(test), .cpu_reset(cpu_reset), .resetpc(resetpc),
      .memoryoperation(memoryoperation), .memorywrite(memorywrite),
      .memaddress(memaddress), .memwritedata(memwritedata),
      .registeroperation(registeroperation), .registerwrite(registerwrite),
      .registeraddress(registeraddress), .regwritedata(regwritedata),
      .MD(MD), .RD(RD), .PC(PC), .cpu_state(cpu_state)
   );

   always #5 clk = ~clk;

   // ---------------- environment: memory, register file, CPU ----------------
   logic [15:0] env_mem [256];
   logic [15:0] env_reg [16];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= 16'h0000;
         for (int i = 0; i < 16; i++) env_reg[i] <= 16'h0000;
      end else begin
         if (memoryoperation && memorywrite) env_mem[memaddress[7:0]] <= memwritedata;
         if (registeroperation && registerwrite && registeraddress != 4'h0)
            env_reg[registeraddress] <= regwritedata;
      end
   end

   assign MD = env_mem[memaddress[7:0]] ^ ((memaddress[7:0] == FAULT) ? 16'h0001 : 16'h0000);
   assign RD = env_reg[registeraddress];

   // Instruction length in cycles, fetch included (always >= 3).
   function automatic int ilen(input logic [15:0] p);
      return 3 + int'(p % 16'd3);
   endfunction

   logic [15:0] cpu_pc = 16'h0000;
   logic [3:0]  phase  = 4'd0;
   assign PC        = cpu_pc;
   assign cpu_state = 9'd1 << phase;   // phase 0 is fetch (9'd1)

   always @(posedge clk) begin
      if (cpu_reset) begin
         cpu_pc <= resetpc;
         phase  <= 4'd0;
      end else if (test) begin
         if (phase == 4'(ilen(cpu_pc) - 1)) begin
            phase  <= 4'd0;
            cpu_pc <= cpu_pc + 16'd1;
         end else begin
            phase <= phase + 4'd1;
         end
      end
   end

   // ---------------- activity monitor ----------------
   int memwr_cnt = 0, regwr_cnt = 0, sel_cnt = 0, test_cnt = 0;
   int rst_cnt = 0, rsp_cnt = 0, bad_cnt = 0;

   always @(negedge clk) begin
      memwr_cnt <= memwr_cnt + int'(memoryoperation && memorywrite);
      regwr_cnt <= regwr_cnt + int'(registeroperation && registerwrite);
      sel_cnt   <= sel_cnt + int'(memoryoperation || registeroperation);
      test_cnt  <= test_cnt + int'(test);
      rst_cnt   <= rst_cnt + int'(cpu_reset);
      rsp_cnt   <= rsp_cnt + int'(rsp_valid);
      bad_cnt   <= bad_cnt + int'((memoryoperation && registeroperation) ||
                                  (test && (memoryoperation || registeroperation)) ||
                                  (memorywrite && !memoryoperation) ||
                                  (registerwrite && !registeroperation));
   end

   // ---------------- checking ----------------
   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   logic [15:0] ref_mem [256];
   logic [15:0] ref_reg [16];

   // Issue one command and wait (bounded) for its response.
   task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic re, output int lat);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 5000) begin @(negedge clk); lat++; end
      rd = rsp_data;
      re = rsp_err;
      @(negedge clk);
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
   endtask

   // Memory/register access with expectations from the command-level model.
   task automatic xfer(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d);
      logic [15:0] ed, rd;
      logic        ee, re;
      int          lat, m0, r0, s0, t0;
      case (op)
         3'd1: begin
            ref_mem[a[7:0]] = d;
            ed = (a[7:0] == FAULT) ? (d ^ 16'h0001) : d;
            ee = (ed != d);
         end
         3'd0: begin
            ed = ref_mem[a[7:0]] ^ ((a[7:0] == FAULT) ? 16'h0001 : 16'h0000);
            ee = 1'b0;
         end
         3'd3: begin
            if (a[3:0] != 4'h0) ref_reg[a[3:0]] = d;
            ed = ref_reg[a[3:0]];
            ee = (ed != d);
         end
         default: begin
            ed = ref_reg[a[3:0]];
            ee = 1'b0;
         end
      endcase
      m0 = memwr_cnt; r0 = regwr_cnt; s0 = sel_cnt; t0 = test_cnt;
      do_cmd(op, a, d, rd, re, lat);
      chk("acc_rsp_data", 32'(rd), 32'(ed));
      chk("acc_rsp_err", 32'(re), 32'(ee));
      chk("acc_latency", 32'(lat), 32'(ACC + 1));
      chk("mem_wr_cycles", 32'(memwr_cnt - m0), (op == 3'd1) ? 32'(ACC) : 32'd0);
      chk("reg_wr_cycles", 32'(regwr_cnt - r0), (op == 3'd3) ? 32'(ACC) : 32'd0);
      chk("select_cycles", 32'(sel_cnt - s0), 32'(ACC + 1));
      chk("no_test_in_acc", 32'(test_cnt - t0), 32'd0);
   endtask

   // RUN command: final PC is start+N, test is high for the N instructions.
   task automatic run_cmd(input logic [15:0] s, input logic [15:0] n);
      logic [15:0] rd;
      logic        re;
      int          lat, t0, c0, sum;
      sum = 0;
      for (int i = 0; i < int'(n); i++) sum += ilen(s + 16'(i));
      t0 = test_cnt; c0 = rst_cnt;
      do_cmd(3'd4, s, n, rd, re, lat);
      chk("run_completed", 32'(lat < 5000), 32'd1);
      chk("run_final_pc", 32'(rd), 32'(s + n));
      chk("run_err", 32'(re), 32'd0);
      chk("run_test_cycles", 32'(test_cnt - t0), 32'(sum));
      chk("run_cpu_reset_cycles", 32'(rst_cnt - c0), 32'd1);
   endtask

   initial begin
      logic [15:0] rd;
      logic        re;
      int          lat, s0, m0, r0;
      logic [2:0]  op;
      logic [15:0] a;

      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      for (int i = 0; i < 16; i++) ref_reg[i] = 16'h0000;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 16'h0000; cmd_data = 16'h0000;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("reset_ctrl", 32'({cmd_ready, rsp_valid, rsp_err, test, cpu_reset,
                             memoryoperation, memorywrite, registeroperation, registerwrite}),
          32'h100);
      chk("reset_addr", {resetpc, memaddress}, 32'h0);
      chk("reset_data", {memwritedata, regwritedata}, 32'h0);
      chk("reset_misc", 32'({registeraddress, rsp_data}), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // Directed accesses
      xfer(3'd1, 16'h0003, 16'hEE02);
      xfer(3'd0, 16'h0003, 16'h0000);
      xfer(3'd3, 16'h000E, 16'h000B);
      xfer(3'd2, 16'h000E, 16'h0000);
      xfer(3'd3, 16'h0000, 16'h1234);                // register 0 cannot hold data
      xfer(3'd1, {8'h00, FAULT}, 16'h5A5A);          // faulty cell -> readback error

      // Illegal opcode: immediate error response, no port activity
      s0 = sel_cnt; m0 = memwr_cnt; r0 = test_cnt;
      do_cmd(3'd6, 16'h0055, 16'h00AA, rd, re, lat);
      chk("illegal_latency", 32'(lat), 32'd0);
      chk("illegal_err", 32'(re), 32'd1);
      chk("illegal_no_port", 32'((sel_cnt - s0) + (memwr_cnt - m0) + (test_cnt - r0)), 32'd0);

      // Runs, including N=0
      run_cmd(16'h0003, 16'd0);
      run_cmd(16'h0003, 16'd1);
      run_cmd(16'h0003, 16'd2);
      run_cmd(16'h8000, 16'd5);

      // Randomised mix
      for (int k = 0; k < 40; k++) begin
         op = 3'($urandom_range(0, 4));
         if (op == 3'd4) begin
            run_cmd(16'($urandom), 16'($urandom_range(0, 6)));
         end else begin
            a = (op < 3'd2) ? {8'h00, 8'($urandom_range(0, 255))} : {12'h000, 4'($urandom_range(0, 15))};
            if (op < 3'd2 && $urandom_range(0, 7) == 0) a = {8'h00, FAULT};
            xfer(op, a, 16'($urandom));
         end
      end

      // Reset in the middle of a RUN
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 16'h0100; cmd_data = 16'd50;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("run_active", 32'(test), 32'd1);
      s0 = rsp_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_test_low", 32'(test), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_cnt - s0), 32'd0);
      chk("abort_idle", 32'({cmd_ready, test}), 32'h2);

      chk("port_rules", 32'(bad_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
